memory_map: RTL

Address decoder and I/O register bank between the CPU's single memory port and the system block RAM.
- Routes CPU accesses below `IO_BASE` to RAM; accesses at or above `IO_BASE` go to a small memory-mapped register file.
- Registers: LEDs, synchronised switches, a buffered byte-transmit channel (FIFO with valid/ready handshake toward a UART) and a free-running timer.
- Read data returns with the same one-cycle latency as the block RAM, so the CPU controller is unchanged.

---
 rtl/memory_map_pkg.sv | 44 ++++
 rtl/memory_map_tx_fifo.sv | 81 ++++++++
 rtl/memory_map.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/memory_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_map_pkg
//  Description : Shared constants for the CPU memory-map decoder: I/O register
//                offsets, TX status bit positions and a status packing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_map_pkg;

    // I/O register offsets relative to IO_BASE
    localparam logic [15:0] OFF_LEDS     = 16'd0;
    localparam logic [15:0] OFF_SWITCHES = 16'd1;
    localparam logic [15:0] OFF_TX       = 16'd2;
    localparam logic [15:0] OFF_TIMER    = 16'd3;
    localparam logic [15:0] OFF_CTRL     = 16'd4;

    // TX status word layout
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

    // Width of the LED and switch registers
    localparam int LED_W = 10;

    // Assemble the TX status word; unused bits read as zero
    function automatic logic [15:0] pack_status(
        input logic                  full,
        input logic                  empty,
        input logic                  overflow,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [15:0] s;
        s                                 = '0;
        s[ST_FULL]                        = full;
        s[ST_EMPTY]                       = empty;
        s[ST_OVERFLOW]                    = overflow;
        s[ST_COUNT_LSB +: ST_COUNT_W]     = count;
        return s;
    endfunction

endpackage : memory_map_pkg
`default_nettype wire

// File: rtl/memory_map_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous FIFO with occupancy count. Pushes while full and
//                pops while empty are ignored; overflow tracking is left to
//                the instantiating block.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    // Next pointer/count; power-of-two depth lets the pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset empties the FIFO immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : tx_fifo
`default_nettype wire

// File: rtl/memory_map.sv
`default_nettype none
// ============================================================================
//  Module      : memory_map
//  Description : Address decoder between the CPU memory port and block RAM,
//                with an I/O register bank above IO_BASE (LEDs, synchronised
//                switches, buffered byte transmit FIFO, free-running timer).
//                Read data has the same one-cycle latency as the block RAM.
//                Optional feature macro: MEMORY_MAP_TIMER_EN (timer at
//                offset 3; without it offset 3 reads 0 and ignores writes).
//  Revision    : 1.0  initial release
// ============================================================================
module memory_map
    import memory_map_pkg::*;
#(
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_write_enable,
    input  logic [15:0]      cpu_address,
    input  logic [15:0]      cpu_write_data,
    output logic [15:0]      cpu_read_data,
    output logic             ram_write_enable,
    output logic [15:0]      ram_address,
    output logic [15:0]      ram_write_data,
    input  logic [15:0]      ram_read_data,
    input  logic [LED_W-1:0] switches,
    output logic [LED_W-1:0] leds,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Decode
    logic        w_io_hit;
    logic [15:0] w_offset;
    logic        w_io_wr;
    logic        w_wr_leds;
    logic        w_wr_tx;
    logic        w_wr_timer;
    logic        w_wr_ctrl;

    // FIFO interface
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    // Register state
    logic [LED_W-1:0] leds_q, leds_d;
    logic [LED_W-1:0] sw_meta_q;
    logic [LED_W-1:0] sw_sync_q;
    logic             ovf_q, ovf_d;
    logic             io_hit_q;
    logic [15:0]      io_rdata_q, io_rdata_d;
    logic [15:0]      w_timer_value;

    assign w_io_hit = (cpu_address >= IO_BASE);
    assign w_offset = cpu_address - IO_BASE;

    // RAM sees the CPU port directly; only the write strobe is qualified
    assign ram_write_enable = cpu_write_enable & ~w_io_hit;
    assign ram_address      = cpu_address;
    assign ram_write_data   = cpu_write_data;

    assign w_io_wr    = cpu_write_enable & w_io_hit;
    assign w_wr_leds  = w_io_wr & (w_offset == OFF_LEDS);
    assign w_wr_tx    = w_io_wr & (w_offset == OFF_TX);
    assign w_wr_timer = w_io_wr & (w_offset == OFF_TIMER);
    assign w_wr_ctrl  = w_io_wr & (w_offset == OFF_CTRL);

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle
    assign w_push   = w_wr_tx & ~w_full;
    assign w_pop    = tx_valid & tx_ready;
    assign tx_valid = ~w_empty;
    assign leds     = leds_q;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (w_push),
        .data_i  (cpu_write_data[7:0]),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .head_o  (tx_data)
    );

    // LED next state and sticky overflow (set has priority over clear)
    always_comb begin
        leds_d = leds_q;
        ovf_d  = ovf_q;
        if (w_wr_leds) begin
            leds_d = cpu_write_data[LED_W-1:0];
        end
        if (w_wr_tx & w_full) begin
            ovf_d = 1'b1;
        end else if (w_wr_ctrl & cpu_write_data[0]) begin
            ovf_d = 1'b0;
        end
    end

    // LED, overflow and two-flop switch synchroniser state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_q    <= '0;
            ovf_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            leds_q    <= leds_d;
            ovf_q     <= ovf_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef MEMORY_MAP_TIMER_EN
    logic [15:0] timer_q, timer_d;

    // Free-running timer; a CPU write overrides the increment
    always_comb begin
        timer_d = timer_q + 16'd1;
        if (w_wr_timer) begin
            timer_d = cpu_write_data;
        end
    end

    // Timer state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign w_timer_value = timer_q;
`else
    // No timer: offset 3 reads zero and writes are discarded
    logic w_unused_timer;
    assign w_unused_timer = ^{cpu_write_data[15:LED_W], w_wr_timer};
    assign w_timer_value  = '0;
`endif

    // I/O read mux; values are those held before the current edge updates
    always_comb begin
        io_rdata_d = '0;
        if (w_io_hit) begin
            case (w_offset)
                OFF_LEDS:     io_rdata_d = 16'(leds_q);
                OFF_SWITCHES: io_rdata_d = 16'(sw_sync_q);
                OFF_TX:       io_rdata_d = pack_status(w_full, w_empty, ovf_q,
                                                       ST_COUNT_W'(w_count));
                OFF_TIMER:    io_rdata_d = w_timer_value;
                default:      io_rdata_d = '0;
            endcase
        end
    end

    // Read pipeline stage matching the block RAM's registered output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_hit_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            io_hit_q   <= w_io_hit;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign cpu_read_data = io_hit_q ? io_rdata_q : ram_read_data;

endmodule : memory_map
`default_nettype wire
